alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencer that drives the execute-stage ALU. Accepts one decoded instruction per valid/ready handshake, translates opcode/funct fields into the 4-bit ALU operation code, presents registered operands to the ALU, and captures result and zero flag. Returns a registered result, branch decision and illegal flag downstream. Multiply is held for a configurable settle time because the ALU multiplier is a multicycle path.

## Interface
- MUL_STALL, 2: extra cycles alu_* are held stable before capturing a multiply result (0–15).
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  block can accept this cycle.
- in_opcode  input  7  instruction opcode.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7.
- in_rs1_val  input  32  rs1 operand.
- in_rs2_val  input  32  rs2 operand.
- in_imm  input  32  sign-extended immediate.
- alu_a  output  32  ALU operand A (registered).
- alu_b  output  32  ALU operand B (registered).
- alu_control  output  4  ALU operation code (registered).
- alu_result  input  32  ALU result (combinational from alu_*).
- alu_zero  input  1  ALU zero/condition flag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  32  captured result.
- out_branch_taken  output  1  captured alu_zero for branches, else 0.
- out_illegal  output  1  instruction not supported.

## Operation
- Codes: ADD=2, SUB=6, XOR=4, BGE=7, BEQ=5, MUL=1, SLLI=3, NONE=0.
- Decode:
  - 0110011, f3=000: f7=0000000 ADD, 0100000 SUB, 0000001 MUL; f3=100, f7=0: XOR; B=rs2.
  - 0010011: f3=000 ADD (B=imm); f3=001 with imm[11:0]==12'd2 SLLI (ALU shifts fixed by 2).
  - 0000011 / 0100011 (load/store address): ADD, B=imm.
  - 1100011: f3=000 BEQ, f3=101 BGE (unsigned compare, as the ALU implements); B=rs2.
  - Everything else illegal. A=rs1 always.
- FSM states IDLE, EXEC, MWAIT, HOLD.
  - IDLE: in_ready=1. On in_valid, latch alu_a/alu_b/alu_control → EXEC; illegal → HOLD directly with out_illegal=1, out_result=0, out_branch_taken=0, alu_* unchanged.
  - EXEC: non-MUL captures alu_result, and alu_zero when code is BEQ/BGE, → HOLD. MUL with MUL_STALL>0 loads counter → MWAIT; MUL_STALL=0 captures as non-MUL.
  - MWAIT: decrement; when counter reaches 1, capture → HOLD.
  - HOLD: out_valid=1, outputs stable. On out_ready: in_ready=1 in the same cycle (in_ready = IDLE or (HOLD and out_ready)); if in_valid also high, accept next instruction (→ EXEC or HOLD) else → IDLE.
- alu_* stay at last issued values in IDLE/HOLD.

## Timing
- Reset: state IDLE, alu_a=0, alu_b=0, alu_control=0, out_valid=0, out_result=0, out_branch_taken=0, out_illegal=0; in_ready=1 from reset release.
- Accept at edge t: EXEC during cycle t+1, out_valid from t+2 (non-MUL), t+2+MUL_STALL (MUL), t+1 (illegal).
- Back-to-back throughput: one instruction per 2 cycles (non-MUL) with out_ready tied high.
- out_valid never deasserts without out_ready handshake.
- Reset mid-operation discards in-flight instruction; no output produced.

## Configuration
- ALU_ISSUE_MUL_EN defined: MUL decoded, MWAIT state present.
- Undefined: f7=0000001 R-type treated as illegal; MWAIT and counter removed; MUL_STALL ignored.

## Structure
- Shared package alu_pkg: ALU operation code constants, opcode constants, FSM state typedef.
- One sub-module alu_op_decode: combinational opcode/funct → {alu_control, use_imm, is_branch, illegal}.

## Test plan
- ADD rs1=5, rs2=7 with out_ready=1 → alu_control=2, out_result=12 two cycles after accept, out_illegal=0.
- BEQ rs1=rs2=0x55 → out_branch_taken=1; BGE rs1=3, rs2=9 → out_branch_taken=0.
- MUL 0x10000×0x10 with MUL_STALL=2 → out_valid 4 cycles after accept, out_result=0x100000; without ALU_ISSUE_MUL_EN → out_illegal=1 one cycle after accept.
- SLLI shamt=2 on 0x3 → out_result=0xC; SLLI shamt=3 → out_illegal=1, out_result=0.
- out_ready low for 5 cycles in HOLD → out_valid, out_result stable, in_ready=0; release with in_valid high → next accepted same cycle.
- rst_n asserted during MWAIT → all outputs zero, in_ready=1, no out_valid after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU sequencer: ALU operation codes,
// RV32 major opcodes, and the issue FSM state type.
// MWAIT exists only when ALU_ISSUE_MUL_EN is defined (multiply support).
package alu_pkg;

  // ALU operation codes as understood by the execute-stage ALU
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_MUL  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLLI = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_BEQ  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_BGE  = 4'd7;

  // Major opcodes handled by this block
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
`ifdef ALU_ISSUE_MUL_EN
    MWAIT = 2'd3,
`endif
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Purpose: translate opcode/funct3/funct7/imm[11:0] into the ALU op code and
//          operand-B select, flagging branches and unsupported encodings.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: opcode/funct3/funct7/imm_lo in; alu_control, use_imm, is_branch, illegal out.
// Config: ALU_ISSUE_MUL_EN enables decoding of the R-type multiply (funct7=0000001).
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm_lo,
  output logic [3:0]  alu_control,
  output logic        use_imm,
  output logic        is_branch,
  output logic        illegal
);

  always_comb begin
    alu_control = ALU_NONE;
    use_imm     = 1'b0;
    is_branch   = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_REG: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          alu_control = ALU_ADD;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          alu_control = ALU_SUB;
`ifdef ALU_ISSUE_MUL_EN
        end else if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
          alu_control = ALU_MUL;
`endif
        end else if (funct3 == 3'b100 && funct7 == 7'b0000000) begin
          alu_control = ALU_XOR;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        use_imm = 1'b1;
        if (funct3 == 3'b000) begin
          alu_control = ALU_ADD;
        end else if (funct3 == 3'b001 && imm_lo == 12'd2) begin
          // the ALU shifter is hard-wired to a shift of 2; any other amount is unsupported
          alu_control = ALU_SLLI;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LOAD, OP_STORE: begin
        // address generation only
        alu_control = ALU_ADD;
        use_imm     = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          alu_control = ALU_BEQ;
          is_branch   = 1'b1;
        end else if (funct3 == 3'b101) begin
          alu_control = ALU_BGE;
          is_branch   = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose: issue one decoded instruction at a time to the execute ALU and hold its result.
// Latency: accept->out_valid 2 cycles (non-MUL), 2+MUL_STALL (MUL), 1 (illegal).
// Backpressure: in_ready only in IDLE or in HOLD with out_ready; result held until out_ready.
// Ports: in_* valid/ready instruction in; alu_a/alu_b/alu_control to the ALU, alu_result/alu_zero
//        back; out_* valid/ready result, branch decision and illegal flag.
// Config: define ALU_ISSUE_MUL_EN to decode multiply and hold it MUL_STALL extra cycles (MWAIT).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter logic [3:0] MUL_STALL = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_branch_taken,
  output logic        out_illegal
);

  state_t     state_q, state_d;
  logic [3:0] dec_control;
  logic       dec_use_imm;
  logic       dec_is_branch;
  logic       dec_illegal;
  logic       is_branch_q;
  logic       accept;
  logic       capture;

  alu_op_decode u_decode (
    .opcode      (in_opcode),
    .funct3      (in_funct3),
    .funct7      (in_funct7),
    .imm_lo      (in_imm[11:0]),
    .alu_control (dec_control),
    .use_imm     (dec_use_imm),
    .is_branch   (dec_is_branch),
    .illegal     (dec_illegal)
  );

  // HOLD releases its result and takes the next instruction in the same cycle
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);

`ifdef ALU_ISSUE_MUL_EN
  logic [3:0] cnt_q;
  logic       cnt_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (cnt_load) begin
      cnt_q <= MUL_STALL;
    end else if (state_q == MWAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
`else
  logic [3:0] unused_mul_stall;
  assign unused_mul_stall = MUL_STALL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
`ifdef ALU_ISSUE_MUL_EN
    cnt_load = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = dec_illegal ? HOLD : EXEC;
        end
      end
      EXEC: begin
`ifdef ALU_ISSUE_MUL_EN
        if (alu_control == ALU_MUL && MUL_STALL != 4'd0) begin
          cnt_load = 1'b1;
          state_d  = MWAIT;
        end else
`endif
        begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
`ifdef ALU_ISSUE_MUL_EN
      MWAIT: begin
        // alu_* have been stable for MUL_STALL cycles once the counter hits 1
        if (cnt_q == 4'd1) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
`endif
      HOLD: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = dec_illegal ? HOLD : EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU operands only change on a legal accept, so they stay put through illegal results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_control <= ALU_NONE;
      is_branch_q <= 1'b0;
    end else if (accept && !dec_illegal) begin
      alu_a       <= in_rs1_val;
      alu_b       <= dec_use_imm ? in_imm : in_rs2_val;
      alu_control <= dec_control;
      is_branch_q <= dec_is_branch;
    end
  end

  // accept (IDLE/HOLD) and capture (EXEC/MWAIT) never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result       <= 32'd0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else if (accept && dec_illegal) begin
      out_result       <= 32'd0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b1;
    end else if (capture) begin
      out_result       <= alu_result;
      out_branch_taken <= is_branch_q ? alu_zero : 1'b0;
      out_illegal      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose: directed-vector bench for alu_issue_ctrl with a behavioural execute ALU.
// Latency: results checked against hand-computed values and cycle counts.
// Backpressure: out_ready held low in HOLD to exercise stalls, then released.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = 7'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_rs1_val = 32'd0;
  logic [31:0] in_rs2_val = 32'd0;
  logic [31:0] in_imm = 32'd0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_branch_taken;
  logic        out_illegal;

  int n_vec = 0;
  int n_miscmp = 0;

`ifdef ALU_ISSUE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.MUL_STALL(4'd2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_opcode        (in_opcode),
    .in_funct3        (in_funct3),
    .in_funct7        (in_funct7),
    .in_rs1_val       (in_rs1_val),
    .in_rs2_val       (in_rs2_val),
    .in_imm           (in_imm),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_control      (alu_control),
    .alu_result       (alu_result),
    .alu_zero         (alu_zero),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal)
  );

  // Execute ALU: branches produce a-b, zero flag carries the branch condition
  always_comb begin
    alu_result = 32'd0;
    alu_zero   = 1'b0;
    case (alu_control)
      4'd2: alu_result = alu_a + alu_b;
      4'd6: alu_result = alu_a - alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd1: alu_result = alu_a * alu_b;
      4'd3: alu_result = alu_a << 2;
      4'd5: alu_result = alu_a - alu_b;
      4'd7: alu_result = alu_a - alu_b;
      default: alu_result = 32'd0;
    endcase
    if (alu_control == 4'd5)      alu_zero = (alu_a == alu_b);
    else if (alu_control == 4'd7) alu_zero = (alu_a >= alu_b);
    else                          alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from IDLE; returns one cycle after the accepting edge
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    in_opcode  = op;
    in_funct3  = f3;
    in_funct7  = f7;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    in_imm     = imm;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
  endtask

  // Cycles from accept to out_valid, bounded
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [31:0] imm, input logic [3:0] exp_ctrl, input int exp_lat,
                     input logic [31:0] exp_res, input logic exp_br, input logic exp_ill);
    int lat;
    send(op, f3, f7, rs1, rs2, imm);
    check({tag, "_ctrl"}, {28'd0, alu_control}, {28'd0, exp_ctrl});
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, out_result, exp_res);
    check({tag, "_br"}, {31'd0, out_branch_taken}, {31'd0, exp_br});
    check({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int acc;
    int seen;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_ctrl", {28'd0, alu_control}, 32'd0);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_res", out_result, 32'd0);
    check("rst_br", {31'd0, out_branch_taken}, 32'd0);
    check("rst_ill", {31'd0, out_illegal}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    //  tag      opcode       f3      f7           rs1           rs2           imm          ctrl lat res           br    ill
    run("add",   7'b0110011, 3'b000, 7'b0000000, 32'd5,        32'd7,        32'd0,        4'd2, 2, 32'd12,       1'b0, 1'b0);
    run("sub",   7'b0110011, 3'b000, 7'b0100000, 32'd20,       32'd7,        32'd0,        4'd6, 2, 32'd13,       1'b0, 1'b0);
    run("xor",   7'b0110011, 3'b100, 7'b0000000, 32'h0000F0F0, 32'h00000FF0, 32'd0,        4'd4, 2, 32'h0000FF00, 1'b0, 1'b0);
    run("addi",  7'b0010011, 3'b000, 7'b0000000, 32'd100,      32'd999,      32'hFFFFFFFC, 4'd2, 2, 32'd96,       1'b0, 1'b0);
    run("load",  7'b0000011, 3'b010, 7'b0000000, 32'h00001000, 32'd0,        32'h00000020, 4'd2, 2, 32'h00001020, 1'b0, 1'b0);
    run("beq",   7'b1100011, 3'b000, 7'b0000000, 32'h55,       32'h55,       32'd0,        4'd5, 2, 32'd0,        1'b1, 1'b0);
    run("bge_n", 7'b1100011, 3'b101, 7'b0000000, 32'd3,        32'd9,        32'd0,        4'd7, 2, 32'hFFFFFFFA, 1'b0, 1'b0);
    run("bge_t", 7'b1100011, 3'b101, 7'b0000000, 32'd9,        32'd3,        32'd0,        4'd7, 2, 32'd6,        1'b1, 1'b0);
    run("slli",  7'b0010011, 3'b001, 7'b0000000, 32'h3,        32'd0,        32'd2,        4'd3, 2, 32'hC,        1'b0, 1'b0);
    // bad shift amount: illegal, ALU inputs keep the SLLI issue
    run("slli3", 7'b0010011, 3'b001, 7'b0000000, 32'h7,        32'd0,        32'd3,        4'd3, 1, 32'd0,        1'b0, 1'b1);
    check("slli3_a", alu_a, 32'h3);
    if (MUL_ON) begin
      run("mul", 7'b0110011, 3'b000, 7'b0000001, 32'h10000, 32'h10, 32'd0, 4'd1, 4, 32'h100000, 1'b0, 1'b0);
      run("unk", 7'b1111111, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0, 4'd1, 1, 32'd0, 1'b0, 1'b1);
    end else begin
      run("mul", 7'b0110011, 3'b000, 7'b0000001, 32'h10000, 32'h10, 32'd0, 4'd3, 1, 32'd0, 1'b0, 1'b1);
      run("unk", 7'b1111111, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0, 4'd3, 1, 32'd0, 1'b0, 1'b1);
    end

    // backpressure: result held for 5 cycles, then released with a new instruction waiting
    send(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd0);
    wait_valid(lat);
    check("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_vld", {31'd0, out_valid}, 32'd1);
      check("bp_res", out_result, 32'd3);
      check("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_rs1_val = 32'd10;
    in_rs2_val = 32'd20;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    check("bp_rdy_rel", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_next_a", alu_a, 32'd10);
    check("bp_next_vld", {31'd0, out_valid}, 32'd0);
    step();
    check("bp_next_res", out_result, 32'd30);
    check("bp_next_vld2", {31'd0, out_valid}, 32'd1);
    step();
    out_ready = 1'b0;
    check("bp_idle", {31'd0, out_valid}, 32'd0);

    // throughput: one accept every two cycles with out_ready tied high
    in_rs1_val = 32'd4;
    in_rs2_val = 32'd4;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    check("tput_acc", acc, 5);
    check("tput_res", out_result, 32'd8);
    step();
    out_ready = 1'b0;
    check("tput_idle", {31'd0, out_valid}, 32'd0);

    // reset mid-operation (MWAIT when multiply is built in, EXEC otherwise)
    if (MUL_ON) begin
      send(7'b0110011, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0);
      step();
    end else begin
      send(7'b0110011, 3'b000, 7'b0000000, 32'd6, 32'd7, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check("mrst_a", alu_a, 32'd0);
    check("mrst_b", alu_b, 32'd0);
    check("mrst_ctrl", {28'd0, alu_control}, 32'd0);
    check("mrst_vld", {31'd0, out_valid}, 32'd0);
    check("mrst_res", out_result, 32'd0);
    check("mrst_rdy", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("mrst_no_out", seen, 0);
    check("mrst_rdy2", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
